// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshake, status flags, flush, and an iterative shift-add multiplier
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int MUL_BPC = 1,
    parameter logic [3:0] OP_ADD = 4'd0,
    parameter logic [3:0] OP_SUB = 4'd1,
    parameter logic [3:0] OP_MUL = 4'd2,
    parameter logic [3:0] OP_BEQ = 4'd3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] w,
    output logic [WIDTH-1:0] w_hi,
    output logic             zero,
    output logic             carry,
    output logic             ovf
);
    localparam int N = WIDTH / MUL_BPC;
    localparam int CW = $clog2(N + 1);
    localparam int PW = WIDTH + MUL_BPC;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [2*WIDTH-1:0] prod, prod_nx;
    logic [WIDTH-1:0] mcand, res;
    logic [WIDTH:0] sum, diff;
    logic [PW-1:0] part;
    logic is_add, is_sub, is_mul, accept;

    assign in_ready = (state == IDLE || (state == DONE && out_ready)) && !flush;
    assign accept = in_valid && in_ready;
    assign out_valid = state == DONE;
    assign is_add = op == OP_ADD;
    assign is_sub = op == OP_SUB || op == OP_BEQ;
    assign is_mul = op == OP_MUL;
    assign sum = {1'b0, x} + {1'b0, y};
    assign diff = {1'b0, x} - {1'b0, y};
    assign res = is_add ? sum[WIDTH-1:0] : is_sub ? diff[WIDTH-1:0] : x;
    // prod holds {partial sum, unretired multiplier bits}; each step retires MUL_BPC bits
    assign part = PW'(prod[2*WIDTH-1:WIDTH]) + PW'(mcand) * PW'(prod[MUL_BPC-1:0]);
    assign prod_nx = {part, prod[WIDTH-1:MUL_BPC]};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = flush ? IDLE
                 : accept ? (is_mul ? BUSY : DONE)
                 : state == BUSY ? (cnt == CW'(1) ? DONE : BUSY)
                 : (state == DONE && !out_ready) ? DONE : IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            prod <= '0;
            mcand <= '0;
            w <= '0;
            w_hi <= '0;
            zero <= 1'b0;
            carry <= 1'b0;
            ovf <= 1'b0;
        end else if (flush) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= is_mul ? CW'(N) : '0;
            prod <= {{WIDTH{1'b0}}, y};
            mcand <= x;
            w <= res;
            w_hi <= '0;
            zero <= (is_add || is_sub) && res == '0;
            carry <= is_add ? sum[WIDTH] : is_sub && !diff[WIDTH];
            ovf <= is_add ? (x[WIDTH-1] == y[WIDTH-1] && sum[WIDTH-1] != x[WIDTH-1])
                          : is_sub && x[WIDTH-1] != y[WIDTH-1] && diff[WIDTH-1] != x[WIDTH-1];
        end else if (state == BUSY) begin
            cnt <= cnt - CW'(1);
            prod <= prod_nx;
            if (cnt == CW'(1)) begin
                w <= prod_nx[WIDTH-1:0];
                w_hi <= prod_nx[2*WIDTH-1:WIDTH];
                zero <= prod_nx[WIDTH-1:0] == '0;
                carry <= 1'b0;
                ovf <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench driving a MUL_BPC=1 and a MUL_BPC=4 alu_mc with identical stimulus
module tb_alu_mc;
    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, MUL = 4'd2, BEQ = 4'd3, MOV = 4'd4;
    logic clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 1;
    logic [3:0] op = 0;
    logic [31:0] x = 0, y = 0;
    logic rdy0, rdy1, ov0, ov1, z0, z1, c0, c1, o0, o1;
    logic [31:0] w0, w1, wh0, wh1;
    int checks = 0, errors = 0, cyc = 0;
    typedef struct { logic [31:0] w, wh; logic z, c, o; int edges; } exp_t;
    exp_t sb0[$], sb1[$];
    int acc0[$], acc1[$];
    logic seen0 = 0, seen1 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_mc #(.WIDTH(32), .MUL_BPC(1), .OP_ADD(ADD), .OP_SUB(SUB), .OP_MUL(MUL), .OP_BEQ(BEQ)) u0 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy0), .op(op),
        .x(x), .y(y), .out_valid(ov0), .out_ready(out_ready), .w(w0), .w_hi(wh0),
        .zero(z0), .carry(c0), .ovf(o0));
    alu_mc #(.WIDTH(32), .MUL_BPC(4), .OP_ADD(ADD), .OP_SUB(SUB), .OP_MUL(MUL), .OP_BEQ(BEQ)) u1 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy1), .op(op),
        .x(x), .y(y), .out_valid(ov1), .out_ready(out_ready), .w(w1), .w_hi(wh1),
        .zero(z1), .carry(c1), .ovf(o1));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cmp(input string n, input exp_t e, input int acc, input logic first,
                       input logic [31:0] w, wh, input logic z, c, o);
        chk({n, " w"}, 64'(w), 64'(e.w));
        chk({n, " w_hi"}, 64'(wh), 64'(e.wh));
        chk({n, " flags"}, 64'({z, c, o}), 64'({e.z, e.c, e.o}));
        if (first) chk({n, " latency"}, 64'(cyc - acc), 64'(e.edges));
    endtask

    // Monitor: latency counts edges from the accepting edge to the edge that raises out_valid
    initial forever begin
        @(negedge clk);
        if (ov0) begin
            if (sb0.size() == 0 || acc0.size() == 0) begin
                checks++; errors++;
                $display("FAIL bpc1 unexpected out_valid w=%0h", w0);
            end else begin
                cmp("bpc1", sb0[0], acc0[0], !seen0, w0, wh0, z0, c0, o0);
                seen0 = 1;
                if (out_ready) begin void'(sb0.pop_front()); void'(acc0.pop_front()); seen0 = 0; end
            end
        end
        if (ov1) begin
            if (sb1.size() == 0 || acc1.size() == 0) begin
                checks++; errors++;
                $display("FAIL bpc4 unexpected out_valid w=%0h", w1);
            end else begin
                cmp("bpc4", sb1[0], acc1[0], !seen1, w1, wh1, z1, c1, o1);
                seen1 = 1;
                if (out_ready) begin void'(sb1.pop_front()); void'(acc1.pop_front()); seen1 = 0; end
            end
        end
        if (reset || flush) begin
            sb0.delete(); sb1.delete(); acc0.delete(); acc1.delete();
            seen0 = 0; seen1 = 0;
        end else begin
            if (in_valid && rdy0) acc0.push_back(cyc + 1);
            if (in_valid && rdy1) acc1.push_back(cyc + 1);
        end
    end

    task automatic issue(input logic [3:0] o_, input logic [31:0] a, b);
        logic ok = 0;
        op = o_; x = a; y = b; in_valid = 1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = rdy0 && rdy1;
        end
        if (!ok) begin checks++; errors++; $display("FAIL issue timeout: in_ready=%b%b required 11", rdy0, rdy1); end
        @(posedge clk); #1;
        in_valid = 0; op = SUB; x = ~a; y = ~b;
    endtask

    task automatic run(input logic [3:0] o_, input logic [31:0] a, b, ew, ewh,
                       input logic ez, ec, eo, input int e0, e1);
        sb0.push_back('{ew, ewh, ez, ec, eo, e0});
        sb1.push_back('{ew, ewh, ez, ec, eo, e1});
        issue(o_, a, b);
    endtask

    task automatic drain();
        logic ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = sb0.size() == 0 && sb1.size() == 0;
        end
        if (!ok) begin checks++; errors++; $display("FAIL drain timeout: pending %0d/%0d required 0", sb0.size(), sb1.size()); end
        @(posedge clk); #1;
    endtask

    task automatic zeros(input string n);
        @(negedge clk);
        chk({n, " w bpc1"}, {w0, wh0}, 64'h0);
        chk({n, " w bpc4"}, {w1, wh1}, 64'h0);
        chk({n, " flags"}, 64'({ov0, z0, c0, o0, ov1, z1, c1, o1}), 64'h0);
    endtask

    task automatic idle_ok(input string n);
        @(negedge clk);
        chk({n, " in_ready"}, 64'({rdy0, rdy1}), 64'b11);
        chk({n, " out_valid"}, 64'({ov0, ov1}), 64'b00);
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        zeros("reset");
        @(posedge clk); #1;
        reset = 0;
        idle_ok("idle");
        run(ADD, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 1, 1, 0, 0, 0);
        run(ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 32'h0, 0, 0, 1, 0, 0);
        run(SUB, 32'h80000000, 32'h1, 32'h7FFFFFFF, 32'h0, 0, 1, 1, 0, 0);
        run(SUB, 32'h2, 32'h9, 32'hFFFFFFF9, 32'h0, 0, 0, 0, 0, 0);
        run(BEQ, 32'h5, 32'h5, 32'h0, 32'h0, 1, 1, 0, 0, 0);
        run(BEQ, 32'h3, 32'h5, 32'hFFFFFFFE, 32'h0, 0, 0, 0, 0, 0);
        run(MOV, 32'h1234, 32'h5678, 32'h1234, 32'h0, 0, 0, 0, 0, 0);
        run(4'hF, 32'h0, 32'h9, 32'h0, 32'h0, 0, 0, 0, 0, 0);
        drain();
        run(MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE, 0, 0, 0, 32, 8);
        drain();
        run(MUL, 32'h3, 32'h5, 32'hF, 32'h0, 0, 0, 0, 32, 8);
        drain();
        run(MUL, 32'h10000, 32'h10000, 32'h0, 32'h1, 1, 0, 0, 32, 8);
        drain();
        run(MUL, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 32'h1, 0, 0, 0, 32, 8);
        drain();
        out_ready = 0;
        run(ADD, 32'h3, 32'h4, 32'h7, 32'h0, 0, 0, 0, 0, 0);
        repeat (5) begin
            @(negedge clk);
            chk("backpressure in_ready", 64'({rdy0, rdy1}), 64'b00);
            chk("backpressure out_valid", 64'({ov0, ov1}), 64'b11);
            @(posedge clk); #1;
        end
        out_ready = 1;
        run(SUB, 32'h9, 32'h2, 32'h7, 32'h0, 0, 1, 0, 0, 0);
        drain();
        issue(MUL, 32'h7, 32'h7);
        repeat (4) @(posedge clk);
        #1;
        flush = 1; in_valid = 1; op = ADD; x = 1; y = 1;
        @(negedge clk);
        chk("flush in_ready", 64'({rdy0, rdy1}), 64'b00);
        @(posedge clk); #1;
        flush = 0; in_valid = 0;
        idle_ok("after flush");
        repeat (40) @(posedge clk);
        #1;
        idle_ok("flush quiet");
        issue(MUL, 32'h9, 32'h9);
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        @(posedge clk); #1;
        zeros("reset mid-mul");
        @(posedge clk); #1;
        reset = 0;
        idle_ok("after reset mid-mul");
        out_ready = 0;
        run(ADD, 32'h3, 32'h4, 32'h7, 32'h0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        @(posedge clk); #1;
        zeros("reset in done");
        @(posedge clk); #1;
        reset = 0; out_ready = 1;
        idle_ok("after reset in done");
        run(ADD, 32'h1, 32'h2, 32'h3, 32'h0, 0, 0, 0, 0, 0);
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end
endmodule
